// File: rtl/ble_ram_pkg.sv
// ble_ram_pkg: shared types and constants for the BLE RX / CPU RAM arbiter
package ble_ram_pkg;
  typedef enum logic [1:0] {IDLE, CPU, DMA} state_e;
  localparam int RX_FIFO_DEPTH = 4;
  localparam logic [3:0] LANE0 = 4'b0001;
endpackage

// File: rtl/ble_rx_buf.sv
// ble_rx_buf: RX byte holding register, or a 4-entry FIFO when BLE_RX_FIFO_EN is defined
module ble_rx_buf
  import ble_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
`ifdef BLE_RX_FIFO_EN
  logic [7:0] mem_q [RX_FIFO_DEPTH];
  logic [1:0] wr_q, rd_q;
  logic [2:0] cnt_q;
  logic       push_ok, pop_ok;
  assign push_ok = push_i && (cnt_q != 3'(RX_FIFO_DEPTH) || pop_i);
  assign pop_ok  = pop_i && cnt_q != 3'd0;
  assign full_o  = cnt_q == 3'(RX_FIFO_DEPTH);
  assign empty_o = cnt_q == 3'd0;
  assign data_o  = mem_q[rd_q];
  // storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk_i)
    if (push_ok) mem_q[wr_q] <= data_i;
  // pointers and count; a push on full is taken when a pop frees the slot
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 2'd1;
      if (pop_ok) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + 3'(push_ok) - 3'(pop_ok);
    end
`else
  logic       full_q;
  logic [7:0] data_q;
  assign full_o  = full_q;
  assign empty_o = !full_q;
  assign data_o  = data_q;
  // single slot; a new byte replaces the held one only as it is popped
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (push_i && (!full_q || pop_i)) data_q <= data_i;
      full_q <= push_i ? 1'b1 : (pop_i ? 1'b0 : full_q);
    end
`endif
endmodule

// File: rtl/ble_ram_arbiter.sv
// ble_ram_arbiter: shares the RAM port between the CPU and the BLE RX ring writer (BLE_RX_FIFO_EN deepens the RX buffer)
module ble_ram_arbiter
  import ble_ram_pkg::*;
#(
  parameter int            AW     = 32,
  parameter logic [AW-1:0] ADR_LL = AW'(32'h0000_1000),
  parameter logic [AW-1:0] ADR_UL = AW'(32'h0000_1FFF)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [AW-1:0] i_cpu_adr,
  input  logic [31:0]   i_cpu_dat,
  input  logic [3:0]    i_cpu_sel,
  input  logic          i_cpu_we,
  input  logic          i_cpu_cyc,
  output logic [31:0]   o_cpu_rdt,
  output logic          o_cpu_ack,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_data,
  output logic          o_rx_ready,
  input  logic          i_ptr_clr,
  output logic [AW-1:0] o_wr_ptr,
  output logic          o_overflow,
  output logic [AW-1:0] o_ram_adr,
  output logic [31:0]   o_ram_dat,
  output logic [3:0]    o_ram_sel,
  output logic          o_ram_we,
  output logic          o_ram_cyc,
  input  logic [31:0]   i_ram_rdt,
  input  logic          i_ram_ack
);
  state_e        state_q;
  logic          rr_cpu_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          ovf_q, ovf_d;
  logic          buf_full, buf_empty, pop, clr_now, cpu_g, dma_g, cpu_win, dma_win;
  logic [7:0]    buf_data;

  ble_rx_buf u_buf (
    .clk_i  (i_wb_clk),
    .rst_i  (i_wb_rst),
    .push_i (i_rx_valid),
    .pop_i  (pop),
    .data_i (i_rx_data),
    .data_o (buf_data),
    .full_o (buf_full),
    .empty_o(buf_empty)
  );

  assign cpu_g      = state_q == CPU;
  assign dma_g      = state_q == DMA;
  assign pop        = dma_g && i_ram_ack;
  assign cpu_win    = i_cpu_cyc && (buf_empty || !rr_cpu_q);
  assign dma_win    = !buf_empty && (!i_cpu_cyc || rr_cpu_q);
  assign clr_now    = i_ptr_clr && (!dma_g || i_ram_ack);
  assign o_rx_ready = !buf_full;
  assign o_wr_ptr   = wr_ptr_q;
  assign o_overflow = ovf_q;

  // grant FSM: round-robin on ties, a grant is held until the RAM acks
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) begin
      state_q  <= IDLE;
      rr_cpu_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (cpu_win) begin
        state_q  <= CPU;
        rr_cpu_q <= 1'b1;
      end else if (dma_win) begin
        state_q  <= DMA;
        rr_cpu_q <= 1'b0;
      end
    end else if (i_ram_ack) state_q <= IDLE;

  // ring pointer advance with wrap, clear beats increment; sticky drop flag
  always_comb begin
    wr_ptr_d = clr_now ? ADR_LL : pop ? (wr_ptr_q == ADR_UL ? ADR_LL : wr_ptr_q + AW'(1)) : wr_ptr_q;
    ovf_d    = clr_now ? 1'b0 : (i_rx_valid && buf_full) ? 1'b1 : ovf_q;
  end

  // pointer and overflow state
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) begin
      wr_ptr_q <= ADR_LL;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end

  // RAM port follows the granted master; everything reads zero while idle
  always_comb begin
    o_ram_cyc = cpu_g || dma_g;
    o_ram_we  = cpu_g ? i_cpu_we : dma_g;
    o_ram_adr = cpu_g ? i_cpu_adr : dma_g ? {wr_ptr_q[AW-1:2], 2'b00} : '0;
    o_ram_sel = cpu_g ? i_cpu_sel : dma_g ? LANE0 << wr_ptr_q[1:0] : 4'b0000;
    o_ram_dat = cpu_g ? i_cpu_dat : dma_g ? {4{buf_data}} : '0;
    o_cpu_ack = cpu_g && i_ram_ack;
    o_cpu_rdt = cpu_g ? i_ram_rdt : '0;
  end
endmodule

// File: tb/tb_ble_ram_arbiter.sv
// tb_ble_ram_arbiter: directed vector bench for ble_ram_arbiter
module tb_ble_ram_arbiter;
  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] nxt;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] cpu_adr = '0, cpu_dat = '0, cpu_rdt;
  logic [3:0]  cpu_sel = '0;
  logic        cpu_we = 1'b0, cpu_cyc = 1'b0, cpu_ack;
  logic        rx_valid = 1'b0, rx_ready, ptr_clr = 1'b0, overflow;
  logic [7:0]  rx_data = '0;
  logic [31:0] wr_ptr, ram_adr, ram_dat, ram_rdt;
  logic [3:0]  ram_sel;
  logic        ram_we, ram_cyc, ram_ack, stall = 1'b0, cyc_prev = 1'b0;
  logic        grants[$];
  int          n_chk = 0, n_fail = 0;
  vec_t        vt[5];

  always #5 clk = ~clk;

  ble_ram_arbiter dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we), .i_cpu_cyc(cpu_cyc),
    .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
    .i_ptr_clr(ptr_clr), .o_wr_ptr(wr_ptr), .o_overflow(overflow),
    .o_ram_adr(ram_adr), .o_ram_dat(ram_dat), .o_ram_sel(ram_sel), .o_ram_we(ram_we), .o_ram_cyc(ram_cyc),
    .i_ram_rdt(ram_rdt), .i_ram_ack(ram_ack)
  );

  // servant_ram-like slave: ack one cycle after cyc, read data tagged with address
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ram_ack <= 1'b0;
      ram_rdt <= '0;
    end else begin
      ram_ack <= ram_cyc & !ram_ack & !stall;
      ram_rdt <= 32'h5A5A_0000 | {16'h0, ram_adr[15:0]};
    end

  // grant log: we=0 marks a CPU grant, we=1 a DMA grant
  always @(negedge clk) begin
    if (ram_cyc && !cyc_prev) grants.push_back(ram_we);
    cyc_prev = ram_cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input logic lvl);
    int i = 0;
    while (ram_cyc !== lvl && i < 50) begin
      tick();
      i++;
    end
    if (ram_cyc !== lvl) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_o_ram_cyc: got %b required %b", ram_cyc, lvl);
    end
  endtask

  task automatic dma_byte(input vec_t v);
    push(v.b);
    wait_cyc(1'b1);
    chk("dma adr", ram_adr, v.adr);
    chk("dma sel", {28'h0, ram_sel}, {28'h0, v.sel});
    chk("dma dat", ram_dat, v.dat);
    chk("dma we", {31'h0, ram_we}, 32'h1);
    wait_cyc(1'b0);
    chk("dma wr_ptr", wr_ptr, v.nxt);
  endtask

  task automatic cpu_reads(input int n);
    int acks = 0, i = 0;
    cpu_cyc = 1'b1;
    cpu_we  = 1'b0;
    cpu_sel = 4'hF;
    while (acks < n && i < 100) begin
      tick();
      i++;
      if (cpu_ack) begin
        acks++;
        if (acks == n) cpu_cyc = 1'b0;
      end
    end
    cpu_cyc = 1'b0;
    chk("cpu acks", acks, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int guard;
    vt[0] = '{8'h11, 32'h1000, 4'b0001, 32'h1111_1111, 32'h1001};
    vt[1] = '{8'h22, 32'h1000, 4'b0010, 32'h2222_2222, 32'h1002};
    vt[2] = '{8'hA5, 32'h1000, 4'b0100, 32'hA5A5_A5A5, 32'h1003};
    vt[3] = '{8'h3C, 32'h1000, 4'b1000, 32'h3C3C_3C3C, 32'h1004};
    vt[4] = '{8'h77, 32'h1004, 4'b0001, 32'h7777_7777, 32'h1005};
    do_reset();
    chk("rst wr_ptr", wr_ptr, 32'h1000);
    chk("rst rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("rst ram_cyc", {31'h0, ram_cyc}, 32'h0);
    chk("rst cpu_ack", {31'h0, cpu_ack}, 32'h0);
    chk("rst overflow", {31'h0, overflow}, 32'h0);
    chk("rst ram_adr", ram_adr, 32'h0);
    cpu_adr = 32'h0000_0010;
    cpu_sel = 4'hF;
    cpu_cyc = 1'b1;
    tick();
    chk("cpu cyc n+1", {31'h0, ram_cyc}, 32'h1);
    chk("cpu adr", ram_adr, 32'h10);
    chk("cpu we", {31'h0, ram_we}, 32'h0);
    chk("cpu early ack", {31'h0, cpu_ack}, 32'h0);
    tick();
    chk("cpu ack n+2", {31'h0, cpu_ack}, 32'h1);
    chk("cpu rdt", cpu_rdt, 32'h5A5A_0010);
    cpu_cyc = 1'b0;
    tick();
    chk("cpu back idle", {31'h0, ram_cyc}, 32'h0);
    for (int i = 0; i < 5; i++) dma_byte(vt[i]);
    do_reset();
    grants.delete();
    push(8'h01);
    cpu_reads(2);
    push(8'h02);
    cpu_reads(1);
    wait_cyc(1'b0);
    tick(2);
    chk("grant count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk($sformatf("grant %0d", i), {31'h0, grants[i]}, 32'(i % 2));
    chk("alt wr_ptr", wr_ptr, 32'h1002);
    guard = 0;
    while (wr_ptr != 32'h1FFF && guard < 5000) begin
      push(8'(guard));
      wait_cyc(1'b1);
      wait_cyc(1'b0);
      guard++;
    end
    chk("fill wr_ptr", wr_ptr, 32'h1FFF);
    dma_byte('{8'hE7, 32'h1FFC, 4'b1000, 32'hE7E7_E7E7, 32'h1000});
    stall = 1'b1;
    push(8'h55);
    wait_cyc(1'b1);
    chk("stall rx_ready", {31'h0, rx_ready}, 32'h0);
    push(8'h66);
    chk("ovf set", {31'h0, overflow}, 32'h1);
    stall = 1'b0;
    wait_cyc(1'b0);
    chk("ovf wr_ptr", wr_ptr, 32'h1001);
    chk("ovf sticky", {31'h0, overflow}, 32'h1);
    tick(3);
    chk("dropped no cyc", {31'h0, ram_cyc}, 32'h0);
    chk("ovf rx_ready", {31'h0, rx_ready}, 32'h1);
    ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
    chk("clr ovf", {31'h0, overflow}, 32'h0);
    chk("clr wr_ptr", wr_ptr, 32'h1000);
    dma_byte('{8'h42, 32'h1000, 4'b0001, 32'h4242_4242, 32'h1001});
    stall = 1'b1;
    push(8'h99);
    wait_cyc(1'b1);
    push(8'h98);
    chk("pre-rst ovf", {31'h0, overflow}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst ram_cyc async", {31'h0, ram_cyc}, 32'h0);
    chk("rst wr_ptr async", wr_ptr, 32'h1000);
    chk("rst ovf async", {31'h0, overflow}, 32'h0);
    chk("rst rx_ready async", {31'h0, rx_ready}, 32'h1);
    stall = 1'b0;
    tick();
    rst = 1'b0;
    tick(4);
    chk("byte lost", {31'h0, ram_cyc}, 32'h0);
    chk("post-rst wr_ptr", wr_ptr, 32'h1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
